mig_traffic_checker: RTL and testbench
======================================

Name: mig_traffic_checker

Overview:
Parametrised DDR/MIG traffic generator and read-back checker that sits on the user side of the MIG AXI-less burst controller, in the same position as the team's basic write/read test driver. It writes NUM_BURSTS bursts of a selectable data pattern to consecutive address regions, waits, then reads every region back and compares against a regenerated expected pattern. It also counts mismatches, length errors and timeouts, and can run one pass or loop continuously.

Parameters:
DATA_W, 128, data beat width (multiple of 32)
ADDR_W, 28, controller address width
BURST_LEN, 256, beats per burst (wr_length/rd_length = BURST_LEN-1)
ADDR_STEP, 2048, address increment between bursts
NUM_BURSTS, 4, bursts per pass (>=1)
DELAY_CYC, 100, idle cycles between write phase and read phase
TIMEOUT_CYC, 65535, max cycles per burst phase before timeout
CNT_W, 16, width of error/pass counters

Ports:
ui_clk  in  1  clock
ui_rstn  in  1  asynchronous active-low reset
start  in  1  pulse: begin a test run (ignored unless IDLE)
continuous  in  1  sampled at start: 1 = loop passes until stop
stop  in  1  pulse: finish current pass, then DONE
pattern_sel  in  1  sampled at start: 0 incrementing, 1 LFSR
wr_req  out  1  write burst request
wr_req_addr  out  ADDR_W  write burst start address
wr_length  out  16  BURST_LEN-1
wr_data  out  DATA_W  write beat
wr_busy  in  1  controller accepted/processing write
wr_data_valid  in  1  controller consumed current wr_data
wr_done  in  1  write burst complete
rd_req  out  1  read burst request
rd_req_addr  out  ADDR_W  read burst start address
rd_length  out  16  BURST_LEN-1
rd_data  in  DATA_W  read beat
rd_busy  in  1  controller accepted/processing read
rd_data_valid  in  1  rd_data valid this cycle
rd_done  in  1  read burst complete
busy  out  1  run in progress
done  out  1  high in DONE until next start
err_cnt  out  CNT_W  data-mismatch beats, saturating
len_err_cnt  out  CNT_W  bursts with wrong beat count, saturating
pass_cnt  out  CNT_W  completed passes, saturating
timeout  out  1  sticky: phase exceeded TIMEOUT_CYC
first_err_addr  out  ADDR_W  burst address of first mismatch
first_err_beat  out  16  beat index of first mismatch

Behaviour:
- Reset (async): all outputs 0, state IDLE, pattern seeds cleared. wr_length/rd_length are constant BURST_LEN-1, not reset-dependent.
- States: IDLE, WR, WR_NEXT, DELAY, RD, RD_NEXT, PASS_END, DONE.
- IDLE: start -> clear counters, timeout, first_err_*; latch continuous/pattern_sel; burst index b=0; -> WR. busy=1 in all states except IDLE/DONE.
- WR: wr_req_addr = b*ADDR_STEP (registered). wr_req=1 registered while wr_busy=0 and burst not yet accepted; first cycle wr_busy=1 sets accepted flag and wr_req drops the next cycle, staying 0 until wr_done. wr_data presents beat 0 on entry and advances to the next beat the cycle after each wr_data_valid. wr_done -> WR_NEXT.
- WR_NEXT: b==NUM_BURSTS-1 -> b=0, DELAY; else b++ -> WR.
- DELAY: counts 0..DELAY_CYC-1 -> RD.
- RD: rd_req handshake identical to WR. Each rd_data_valid compares rd_data to expected beat k, k++. Mismatch: err_cnt++ (saturating); if first mismatch of run, latch first_err_addr=b*ADDR_STEP, first_err_beat=k. At rd_done: k != BURST_LEN -> len_err_cnt++. rd_data_valid and rd_done in the same cycle: beat is checked and counted before the length test. -> RD_NEXT.
- RD_NEXT: mirrors WR_NEXT, last burst -> PASS_END.
- PASS_END: pass_cnt++ (saturating); continuous=1 and no stop seen -> WR with next pass seed; else DONE. stop is latched any time busy=1.
- DONE: done=1; start -> as from IDLE.
- Pattern (beat k, burst b, pass p): incrementing = zero-extended (p*NUM_BURSTS+b)*BURST_LEN+k. LFSR = 32-bit Galois LFSR, poly 0x80200003, seed 0xACE1_0000 ^ {p,b}, one step per beat; DATA_W/32 copies, copy i XORed with i. Writer and checker generators are independent instances with identical seeding.
- Timeout: per-phase counter reset on entering WR/RD. Reaching TIMEOUT_CYC -> timeout=1, wr_req=rd_req=0, -> DONE.
- Address arithmetic is modulo 2^ADDR_W (wraps silently).
- Reset mid-operation: immediate return to reset values, no burst completion awaited.

Decomposition:
- Package mig_tg_pkg: state encoding constant/typedef, pattern-select constants, LFSR polynomial and seed constant.
- Sub-module mig_tg_pattern_gen (DATA_W, BURST_LEN): load(pass, burst, mode), advance, data out. Instantiated twice: write generator and expected-data generator.

Test Plan:
- Incrementing, NUM_BURSTS=2, BURST_LEN=4, ideal memory model -> wr_data beats 0..3 then 4..7 at addrs 0 and 2048; err_cnt=0, pass_cnt=1, done=1.
- LFSR mode, same config -> read-back matches, err_cnt=0; first beat burst0 = 32-bit seed replicated/XORed per copy.
- Model corrupts burst1 beat2 -> err_cnt=1, first_err_addr=2048, first_err_beat=2.
- Model issues rd_done after 3 beats on burst0 -> len_err_cnt=1, run still reaches DONE.
- wr_done withheld, TIMEOUT_CYC=50 -> timeout=1 at cycle 50 of WR, wr_req=0, done=1.
- continuous=1, stop pulsed during pass 2 -> pass_cnt=3, then DONE. Separately, ui_rstn pulsed mid-WR -> all outputs 0 next edge.

Source files
------------

// File: rtl/mig_tg_pkg.sv
// mig_tg_pkg
// Shared definitions for the MIG traffic generator / read-back checker:
//   - controller state encoding
//   - data pattern select codes
//   - LFSR polynomial, base seed and step/seed helper functions
package mig_tg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR       = 3'd1,
    ST_WR_NEXT  = 3'd2,
    ST_DELAY    = 3'd3,
    ST_RD       = 3'd4,
    ST_RD_NEXT  = 3'd5,
    ST_PASS_END = 3'd6,
    ST_DONE     = 3'd7
  } tg_state_e;

  localparam logic PAT_INCR = 1'b0;
  localparam logic PAT_LFSR = 1'b1;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED = 32'hACE1_0000;

  // Right-shifting Galois LFSR: when the bit shifted out is 1 the tap mask is
  // folded back in (bit 31 of the mask is the feedback into the MSB).
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

  // Each (pass, burst) pair gets its own seed; only the low byte of each index
  // participates so the pair fits in the low half of the 32-bit seed.
  function automatic logic [31:0] lfsr_seed(input logic [15:0] pass_idx,
                                            input logic [15:0] burst_idx);
    return LFSR_SEED ^ {16'h0000, pass_idx[7:0], burst_idx[7:0]};
  endfunction

endpackage

// File: rtl/mig_tg_pattern_gen.sv
// mig_tg_pattern_gen
// Regenerable beat-data source. Used once to produce write data and once to
// produce the expected read data; both instances seed identically so the
// checker can recompute any burst without storing it.
// Ports:
//   ui_clk, ui_rstn : clock, asynchronous active-low reset
//   load            : seed for (pass_idx, burst_idx) in the given mode; data
//                     shows beat 0 on the following cycle
//   pass_idx        : pass number used for seeding
//   burst_idx       : burst number within the pass used for seeding
//   mode            : PAT_INCR or PAT_LFSR, captured on load
//   advance         : step to the next beat (data updates next cycle)
//   data            : current beat, registered
module mig_tg_pattern_gen
  import mig_tg_pkg::*;
#(
  parameter int DATA_W     = 128,
  parameter int BURST_LEN  = 256,
  parameter int NUM_BURSTS = 4
) (
  input  logic              ui_clk,
  input  logic              ui_rstn,
  input  logic              load,
  input  logic [15:0]       pass_idx,
  input  logic [15:0]       burst_idx,
  input  logic              mode,
  input  logic              advance,
  output logic [DATA_W-1:0] data
);

  localparam int COPIES = DATA_W / 32;

  logic        mode_r;
  logic [31:0] state_r;
  logic [31:0] seed_s;
  logic [31:0] next_s;
  logic [31:0] incr_base_s;

  // Incrementing mode is a plain 32-bit counter zero-extended to the beat;
  // LFSR mode replicates the 32-bit state with each copy XORed by its index.
  function automatic logic [DATA_W-1:0] expand(input logic [31:0] w, input logic m);
    logic [DATA_W-1:0] r;
    r = '0;
    if (m == PAT_LFSR) begin
      for (int i = 0; i < COPIES; i++) begin
        r[i*32 +: 32] = w ^ 32'(i);
      end
    end else begin
      r[31:0] = w;
    end
    return r;
  endfunction

  // Seed for the requested burst and the successor of the current state.
  always_comb begin
    incr_base_s = (32'(pass_idx) * 32'(NUM_BURSTS) + 32'(burst_idx)) * 32'(BURST_LEN);
    seed_s      = 32'h0000_0000;
    next_s      = state_r;
    if (mode == PAT_LFSR) begin
      seed_s = lfsr_seed(pass_idx, burst_idx);
    end else begin
      seed_s = incr_base_s;
    end
    if (mode_r == PAT_LFSR) begin
      next_s = lfsr_step(state_r);
    end else begin
      next_s = state_r + 32'd1;
    end
  end

  // Pattern state and registered beat output.
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      mode_r  <= PAT_INCR;
      state_r <= 32'h0000_0000;
      data    <= '0;
    end else if (load) begin
      mode_r  <= mode;
      state_r <= seed_s;
      data    <= expand(seed_s, mode);
    end else if (advance) begin
      state_r <= next_s;
      data    <= expand(next_s, mode_r);
    end
  end

endmodule

// File: rtl/mig_traffic_checker.sv
// mig_traffic_checker
// Writes NUM_BURSTS bursts of a selectable pattern to consecutive regions,
// idles DELAY_CYC cycles, reads every region back and checks it against a
// regenerated pattern. Runs one pass or loops until stop.
// Ports:
//   ui_clk, ui_rstn        : clock, asynchronous active-low reset
//   start/continuous/stop  : run control; continuous and pattern_sel are
//   pattern_sel            :   captured at start
//   wr_req..wr_done        : write-burst interface to the controller
//   rd_req..rd_done        : read-burst interface to the controller
//   busy, done             : run status
//   err_cnt, len_err_cnt   : saturating mismatch / bad-length counters
//   pass_cnt               : saturating completed-pass counter
//   timeout                : sticky, a burst phase ran out of cycles
//   first_err_addr/_beat   : location of the first data mismatch of the run
module mig_traffic_checker
  import mig_tg_pkg::*;
#(
  parameter int DATA_W      = 128,
  parameter int ADDR_W      = 28,
  parameter int BURST_LEN   = 256,
  parameter int ADDR_STEP   = 2048,
  parameter int NUM_BURSTS  = 4,
  parameter int DELAY_CYC   = 100,
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16
) (
  input  logic              ui_clk,
  input  logic              ui_rstn,
  input  logic              start,
  input  logic              continuous,
  input  logic              stop,
  input  logic              pattern_sel,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_req_addr,
  output logic [15:0]       wr_length,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_busy,
  input  logic              wr_data_valid,
  input  logic              wr_done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [15:0]       rd_length,
  input  logic [DATA_W-1:0] rd_data,
  input  logic              rd_busy,
  input  logic              rd_data_valid,
  input  logic              rd_done,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  len_err_cnt,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic              timeout,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       first_err_beat
);

  tg_state_e         state_r;
  logic [15:0]       burst_r;
  logic [15:0]       pass_idx_r;
  logic              cont_r;
  logic              mode_r;
  logic              stop_r;
  logic              accepted_r;
  logic              first_err_seen_r;
  logic [31:0]       delay_cnt_r;
  logic [31:0]       to_cnt_r;
  logic [31:0]       beat_k_r;

  logic              wr_load_s;
  logic              rd_load_s;
  logic [15:0]       load_pass_s;
  logic [15:0]       load_burst_s;
  logic              gen_mode_s;
  logic              wr_adv_s;
  logic              rd_adv_s;
  logic [DATA_W-1:0] exp_data_s;
  logic              last_burst_s;
  logic              delay_done_s;
  logic              to_hit_s;
  logic              continue_s;
  logic              beat_mism_s;
  logic [31:0]       rd_beats_s;

  assign wr_length = 16'(BURST_LEN - 1);
  assign rd_length = 16'(BURST_LEN - 1);

  // Burst start address; wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] burst_addr(input logic [15:0] b);
    return ADDR_W'(64'(b) * 64'(ADDR_STEP));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // Transition qualifiers shared by the FSM and the generator controls.
  always_comb begin
    last_burst_s = (burst_r == 16'(NUM_BURSTS - 1));
    delay_done_s = (delay_cnt_r == 32'(DELAY_CYC - 1));
    to_hit_s     = (to_cnt_r == 32'(TIMEOUT_CYC - 1));
    // A stop arriving in the PASS_END cycle itself also ends the run.
    continue_s   = cont_r && !(stop_r || stop);
    beat_mism_s  = (rd_data != exp_data_s);
    rd_beats_s   = beat_k_r + (rd_data_valid ? 32'd1 : 32'd0);
    wr_adv_s     = (state_r == ST_WR) && wr_data_valid;
    rd_adv_s     = (state_r == ST_RD) && rd_data_valid;
    if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
      gen_mode_s = pattern_sel;
    end else begin
      gen_mode_s = mode_r;
    end
  end

  // Generators are seeded in the cycle before a burst phase starts so beat 0
  // is already on their output in the first WR/RD cycle.
  always_comb begin
    wr_load_s    = 1'b0;
    rd_load_s    = 1'b0;
    load_pass_s  = pass_idx_r;
    load_burst_s = 16'd0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          wr_load_s   = 1'b1;
          load_pass_s = 16'd0;
        end else begin
          wr_load_s = 1'b0;
        end
      end
      ST_WR_NEXT: begin
        if (!last_burst_s) begin
          wr_load_s    = 1'b1;
          load_burst_s = burst_r + 16'd1;
        end else begin
          wr_load_s = 1'b0;
        end
      end
      ST_DELAY: begin
        if (delay_done_s) begin
          rd_load_s = 1'b1;
        end else begin
          rd_load_s = 1'b0;
        end
      end
      ST_RD_NEXT: begin
        if (!last_burst_s) begin
          rd_load_s    = 1'b1;
          load_burst_s = burst_r + 16'd1;
        end else begin
          rd_load_s = 1'b0;
        end
      end
      ST_PASS_END: begin
        if (continue_s) begin
          wr_load_s   = 1'b1;
          load_pass_s = pass_idx_r + 16'd1;
        end else begin
          wr_load_s = 1'b0;
        end
      end
      default: begin
        wr_load_s = 1'b0;
        rd_load_s = 1'b0;
      end
    endcase
  end

  mig_tg_pattern_gen #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .NUM_BURSTS(NUM_BURSTS)
  ) u_wr_gen (
    .ui_clk   (ui_clk),
    .ui_rstn  (ui_rstn),
    .load     (wr_load_s),
    .pass_idx (load_pass_s),
    .burst_idx(load_burst_s),
    .mode     (gen_mode_s),
    .advance  (wr_adv_s),
    .data     (wr_data)
  );

  mig_tg_pattern_gen #(
    .DATA_W    (DATA_W),
    .BURST_LEN (BURST_LEN),
    .NUM_BURSTS(NUM_BURSTS)
  ) u_exp_gen (
    .ui_clk   (ui_clk),
    .ui_rstn  (ui_rstn),
    .load     (rd_load_s),
    .pass_idx (load_pass_s),
    .burst_idx(load_burst_s),
    .mode     (gen_mode_s),
    .advance  (rd_adv_s),
    .data     (exp_data_s)
  );

  // Main controller FSM with all status/request outputs registered.
  always_ff @(posedge ui_clk or negedge ui_rstn) begin
    if (!ui_rstn) begin
      state_r          <= ST_IDLE;
      burst_r          <= 16'd0;
      pass_idx_r       <= 16'd0;
      cont_r           <= 1'b0;
      mode_r           <= PAT_INCR;
      stop_r           <= 1'b0;
      accepted_r       <= 1'b0;
      first_err_seen_r <= 1'b0;
      delay_cnt_r      <= 32'd0;
      to_cnt_r         <= 32'd0;
      beat_k_r         <= 32'd0;
      wr_req           <= 1'b0;
      wr_req_addr      <= '0;
      rd_req           <= 1'b0;
      rd_req_addr      <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_cnt          <= '0;
      len_err_cnt      <= '0;
      pass_cnt         <= '0;
      timeout          <= 1'b0;
      first_err_addr   <= '0;
      first_err_beat   <= 16'd0;
    end else begin
      if (busy && stop) begin
        stop_r <= 1'b1;
      end
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            err_cnt          <= '0;
            len_err_cnt      <= '0;
            pass_cnt         <= '0;
            timeout          <= 1'b0;
            first_err_addr   <= '0;
            first_err_beat   <= 16'd0;
            first_err_seen_r <= 1'b0;
            cont_r           <= continuous;
            mode_r           <= pattern_sel;
            stop_r           <= 1'b0;
            burst_r          <= 16'd0;
            pass_idx_r       <= 16'd0;
            wr_req           <= 1'b1;
            wr_req_addr      <= burst_addr(16'd0);
            accepted_r       <= 1'b0;
            to_cnt_r         <= 32'd0;
            busy             <= 1'b1;
            done             <= 1'b0;
            state_r          <= ST_WR;
          end
        end
        ST_WR: begin
          // Completion beats the timeout if both land in the same cycle.
          if (wr_done) begin
            wr_req     <= 1'b0;
            accepted_r <= 1'b0;
            state_r    <= ST_WR_NEXT;
          end else if (to_hit_s) begin
            timeout <= 1'b1;
            wr_req  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            to_cnt_r <= to_cnt_r + 32'd1;
            if (!accepted_r && wr_busy) begin
              accepted_r <= 1'b1;
              wr_req     <= 1'b0;
            end else begin
              wr_req <= !accepted_r && !wr_busy;
            end
          end
        end
        ST_WR_NEXT: begin
          if (last_burst_s) begin
            burst_r     <= 16'd0;
            delay_cnt_r <= 32'd0;
            state_r     <= ST_DELAY;
          end else begin
            burst_r     <= burst_r + 16'd1;
            wr_req      <= 1'b1;
            wr_req_addr <= burst_addr(burst_r + 16'd1);
            accepted_r  <= 1'b0;
            to_cnt_r    <= 32'd0;
            state_r     <= ST_WR;
          end
        end
        ST_DELAY: begin
          if (delay_done_s) begin
            rd_req      <= 1'b1;
            rd_req_addr <= burst_addr(16'd0);
            accepted_r  <= 1'b0;
            to_cnt_r    <= 32'd0;
            beat_k_r    <= 32'd0;
            state_r     <= ST_RD;
          end else begin
            delay_cnt_r <= delay_cnt_r + 32'd1;
          end
        end
        ST_RD: begin
          if (rd_data_valid) begin
            beat_k_r <= beat_k_r + 32'd1;
            if (beat_mism_s) begin
              err_cnt <= sat_inc(err_cnt);
              if (!first_err_seen_r) begin
                first_err_seen_r <= 1'b1;
                first_err_addr   <= rd_req_addr;
                first_err_beat   <= beat_k_r[15:0];
              end
            end
          end
          // rd_beats_s already includes a beat delivered alongside rd_done.
          if (rd_done) begin
            if (rd_beats_s != 32'(BURST_LEN)) begin
              len_err_cnt <= sat_inc(len_err_cnt);
            end
            rd_req     <= 1'b0;
            accepted_r <= 1'b0;
            state_r    <= ST_RD_NEXT;
          end else if (to_hit_s) begin
            timeout <= 1'b1;
            rd_req  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end else begin
            to_cnt_r <= to_cnt_r + 32'd1;
            if (!accepted_r && rd_busy) begin
              accepted_r <= 1'b1;
              rd_req     <= 1'b0;
            end else begin
              rd_req <= !accepted_r && !rd_busy;
            end
          end
        end
        ST_RD_NEXT: begin
          if (last_burst_s) begin
            burst_r <= 16'd0;
            state_r <= ST_PASS_END;
          end else begin
            burst_r     <= burst_r + 16'd1;
            rd_req      <= 1'b1;
            rd_req_addr <= burst_addr(burst_r + 16'd1);
            accepted_r  <= 1'b0;
            to_cnt_r    <= 32'd0;
            beat_k_r    <= 32'd0;
            state_r     <= ST_RD;
          end
        end
        ST_PASS_END: begin
          pass_cnt <= sat_inc(pass_cnt);
          if (continue_s) begin
            pass_idx_r  <= pass_idx_r + 16'd1;
            burst_r     <= 16'd0;
            wr_req      <= 1'b1;
            wr_req_addr <= burst_addr(16'd0);
            accepted_r  <= 1'b0;
            to_cnt_r    <= 32'd0;
            state_r     <= ST_WR;
          end else begin
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        default: begin
          wr_req  <= 1'b0;
          rd_req  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mig_traffic_checker.sv
// Bench for mig_traffic_checker: a reactive burst-controller/memory model
// drives the DUT, a monitor checks every consumed write beat against a queue
// of hand-derived expected beats, and run-level status is checked after each
// run completes.
module tb_mig_traffic_checker;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 28;
  localparam int BL     = 4;
  localparam int STEP   = 2048;
  localparam int NB     = 2;
  localparam int DLY    = 8;
  localparam int TMO    = 50;
  localparam int CNT_W  = 16;

  logic              ui_clk = 1'b0;
  logic              ui_rstn = 1'b0;
  logic              start = 1'b0, continuous = 1'b0, stop = 1'b0, pattern_sel = 1'b0;
  logic              wr_req, rd_req, busy, done, timeout;
  logic [ADDR_W-1:0] wr_req_addr, rd_req_addr, first_err_addr;
  logic [15:0]       wr_length, rd_length, first_err_beat;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data = '0;
  logic              wr_busy = 1'b0, wr_data_valid = 1'b0, wr_done = 1'b0;
  logic              rd_busy = 1'b0, rd_data_valid = 1'b0, rd_done = 1'b0;
  logic [CNT_W-1:0]  err_cnt, len_err_cnt, pass_cnt;

  mig_traffic_checker #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BURST_LEN(BL), .ADDR_STEP(STEP),
    .NUM_BURSTS(NB), .DELAY_CYC(DLY), .TIMEOUT_CYC(TMO), .CNT_W(CNT_W)
  ) dut (
    .ui_clk(ui_clk), .ui_rstn(ui_rstn), .start(start), .continuous(continuous),
    .stop(stop), .pattern_sel(pattern_sel),
    .wr_req(wr_req), .wr_req_addr(wr_req_addr), .wr_length(wr_length),
    .wr_data(wr_data), .wr_busy(wr_busy), .wr_data_valid(wr_data_valid),
    .wr_done(wr_done),
    .rd_req(rd_req), .rd_req_addr(rd_req_addr), .rd_length(rd_length),
    .rd_data(rd_data), .rd_busy(rd_busy), .rd_data_valid(rd_data_valid),
    .rd_done(rd_done),
    .busy(busy), .done(done), .err_cnt(err_cnt), .len_err_cnt(len_err_cnt),
    .pass_cnt(pass_cnt), .timeout(timeout), .first_err_addr(first_err_addr),
    .first_err_beat(first_err_beat)
  );

  initial forever #5 ui_clk = ~ui_clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_exp_t;

  wr_exp_t           exp_wr_q[$];
  logic [ADDR_W-1:0] exp_rd_q[$];
  logic [DATA_W-1:0] mem[int];

  int n_checks = 0;
  int n_fail   = 0;

  // Model knobs
  logic hold_wr    = 1'b0;
  logic corrupt_en = 1'b0;
  logic short_rd   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] rep(input logic [31:0] w);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W / 32; i++) r[i*32 +: 32] = w ^ 32'(i);
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] zext(input int v);
    logic [DATA_W-1:0] r;
    r = '0;
    r[31:0] = 32'(v);
    return r;
  endfunction

  // Write side of the controller/memory model (drives #1 after the edge).
  int                wbeat;
  logic [1:0]        wph = 2'd0;
  logic [ADDR_W-1:0] waddr;
  initial forever begin
    @(posedge ui_clk); #1;
    if (!ui_rstn) begin
      wph = 2'd0; wr_busy = 1'b0; wr_data_valid = 1'b0; wr_done = 1'b0;
    end else begin
      case (wph)
        2'd0: if (wr_req && !hold_wr) begin
          wr_busy = 1'b1; waddr = wr_req_addr; wbeat = 0; wph = 2'd1;
        end
        2'd1: if (wbeat < BL) begin
          wr_data_valid = 1'b1;
          mem[int'(waddr) + wbeat] = wr_data;
          wbeat++;
        end else begin
          wr_data_valid = 1'b0; wr_done = 1'b1; wph = 2'd2;
        end
        default: begin
          wr_done = 1'b0; wr_busy = 1'b0; wph = 2'd0;
        end
      endcase
    end
  end

  // Read side of the model. Normal bursts return rd_done with the last beat;
  // the short mode returns 3 beats on address 0 and rd_done a cycle later.
  int                rbeat, rlen, key;
  logic [1:0]        rph = 2'd0;
  logic [ADDR_W-1:0] raddr;
  logic [ADDR_W-1:0] rexp;
  initial forever begin
    @(posedge ui_clk); #1;
    if (!ui_rstn) begin
      rph = 2'd0; rd_busy = 1'b0; rd_data_valid = 1'b0; rd_done = 1'b0;
    end else begin
      case (rph)
        2'd0: begin
          rd_data_valid = 1'b0;
          if (rd_req) begin
            rd_busy = 1'b1; raddr = rd_req_addr; rbeat = 0; rph = 2'd1;
            if (exp_rd_q.size() == 0) begin
              check("rd_addr_unexpected", 64'(raddr), 64'hFFFF_FFFF);
            end else begin
              rexp = exp_rd_q.pop_front();
              check("rd_req_addr", 64'(raddr), 64'(rexp));
            end
          end
        end
        2'd1: begin
          rlen = (short_rd && raddr == '0) ? 3 : BL;
          if (rbeat < rlen) begin
            key = int'(raddr) + rbeat;
            rd_data = mem.exists(key) ? mem[key] : '0;
            if (corrupt_en && raddr == ADDR_W'(2048) && rbeat == 2) rd_data[0] = ~rd_data[0];
            rd_data_valid = 1'b1;
            rbeat++;
            if (rbeat == rlen && !short_rd) begin
              rd_done = 1'b1; rph = 2'd2;
            end
          end else begin
            rd_data_valid = 1'b0; rd_done = 1'b1; rph = 2'd2;
          end
        end
        default: begin
          rd_done = 1'b0; rd_data_valid = 1'b0; rd_busy = 1'b0; rph = 2'd0;
        end
      endcase
    end
  end

  // Scoreboard monitor: every beat the model consumes must match the queue head.
  wr_exp_t e;
  initial forever begin
    @(negedge ui_clk);
    if (ui_rstn && wr_data_valid) begin
      if (exp_wr_q.size() == 0) begin
        check("wr_beat_unexpected", 64'(wr_data[63:0]), 64'hDEAD);
      end else begin
        e = exp_wr_q.pop_front();
        check("wr_req_addr", 64'(wr_req_addr), 64'(e.addr));
        n_checks++;
        if (wr_data !== e.data) begin
          n_fail++;
          $display("FAIL wr_data: got 0x%0h, expected 0x%0h", wr_data, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic push_incr(input int pass_idx);
    wr_exp_t x;
    for (int b = 0; b < NB; b++) begin
      exp_rd_q.push_back(ADDR_W'(b * STEP));
      for (int k = 0; k < BL; k++) begin
        x.addr = ADDR_W'(b * STEP);
        x.data = zext((pass_idx * NB + b) * BL + k);
        exp_wr_q.push_back(x);
      end
    end
  endtask

  task automatic pulse_start(input logic c, input logic s);
    @(negedge ui_clk);
    continuous = c; pattern_sel = s; start = 1'b1;
    @(negedge ui_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3000; i++) begin
      if (done) break;
      @(negedge ui_clk);
    end
    check(name, 64'(done), 64'd1);
  endtask

  task automatic check_status(input string tag, input int errs, input int lens,
                              input int passes, input logic tmo);
    check({tag, "_err_cnt"}, 64'(err_cnt), 64'(errs));
    check({tag, "_len_err_cnt"}, 64'(len_err_cnt), 64'(lens));
    check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(passes));
    check({tag, "_timeout"}, 64'(timeout), 64'(tmo));
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_wrq_empty"}, 64'(exp_wr_q.size()), 64'd0);
    check({tag, "_rdq_empty"}, 64'(exp_rd_q.size()), 64'd0);
  endtask

  logic [31:0] lfsr_tab[8];
  wr_exp_t     lx;
  int          cyc;

  initial begin
    // Reset state
    repeat (3) @(negedge ui_clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_wr_req", 64'(wr_req), 64'd0);
    check("rst_rd_req", 64'(rd_req), 64'd0);
    check("rst_wr_data", 64'(|wr_data), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    check("rst_pass_cnt", 64'(pass_cnt), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("wr_length", 64'(wr_length), 64'd3);
    check("rd_length", 64'(rd_length), 64'd3);
    ui_rstn = 1'b1;

    // 1: incrementing, ideal memory
    push_incr(0);
    pulse_start(1'b0, 1'b0);
    wait_done("t1_done");
    check_status("t1", 0, 0, 1, 1'b0);

    // 2: LFSR, hand-stepped values (seed ^ {pass,burst}, right-shift Galois)
    lfsr_tab = '{32'hACE1_0000, 32'h5670_8000, 32'h2B38_4000, 32'h159C_2000,
                 32'hACE1_0001, 32'hD650_8003, 32'hEB08_4002, 32'h7584_2001};
    for (int i = 0; i < 8; i++) begin
      lx.addr = ADDR_W'((i / BL) * STEP);
      lx.data = rep(lfsr_tab[i]);
      exp_wr_q.push_back(lx);
    end
    exp_rd_q.push_back(ADDR_W'(0));
    exp_rd_q.push_back(ADDR_W'(2048));
    pulse_start(1'b0, 1'b1);
    check("t2_beat0", 64'(wr_data[63:0]), 64'hACE1_0001_ACE1_0000);
    wait_done("t2_done");
    check_status("t2", 0, 0, 1, 1'b0);

    // 3: corrupted read of burst 1 beat 2
    corrupt_en = 1'b1;
    push_incr(0);
    pulse_start(1'b0, 1'b0);
    wait_done("t3_done");
    check_status("t3", 1, 0, 1, 1'b0);
    check("t3_first_err_addr", 64'(first_err_addr), 64'd2048);
    check("t3_first_err_beat", 64'(first_err_beat), 64'd2);
    corrupt_en = 1'b0;

    // 4: short read burst on burst 0
    short_rd = 1'b1;
    push_incr(0);
    pulse_start(1'b0, 1'b0);
    wait_done("t4_done");
    check_status("t4", 0, 1, 1, 1'b0);
    short_rd = 1'b0;

    // 5: write never accepted -> timeout after TMO cycles of WR
    hold_wr = 1'b1;
    pulse_start(1'b0, 1'b0);
    check("t5_wr_req_held", 64'(wr_req), 64'd1);
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      if (timeout) break;
      @(negedge ui_clk);
      cyc++;
    end
    check("t5_timeout_cycle", 64'(cyc), 64'(TMO));
    check("t5_wr_req", 64'(wr_req), 64'd0);
    check("t5_done", 64'(done), 64'd1);
    check_status("t5", 0, 0, 0, 1'b1);
    hold_wr = 1'b0;

    // 6: continuous, stop pulsed during the third pass
    push_incr(0); push_incr(1); push_incr(2);
    pulse_start(1'b1, 1'b0);
    cyc = 0;
    for (int i = 0; i < 3000; i++) begin
      if (pass_cnt == CNT_W'(2) && wr_req) break;
      @(negedge ui_clk);
      cyc++;
    end
    check("t6_reached_pass2", 64'(pass_cnt), 64'd2);
    stop = 1'b1;
    @(negedge ui_clk);
    stop = 1'b0;
    wait_done("t6_done");
    check_status("t6", 0, 0, 3, 1'b0);

    // 7: asynchronous reset in the middle of a write burst
    pulse_start(1'b0, 1'b1);
    check("t7_in_wr", 64'(wr_req), 64'd1);
    #2 ui_rstn = 1'b0;
    #1 check("t7_async_wr_req", 64'(wr_req), 64'd0);
    @(posedge ui_clk); #1;
    check("t7_busy", 64'(busy), 64'd0);
    check("t7_done", 64'(done), 64'd0);
    check("t7_wr_data", 64'(|wr_data), 64'd0);
    check("t7_wr_req_addr", 64'(wr_req_addr), 64'd0);
    check("t7_rd_req", 64'(rd_req), 64'd0);
    check("t7_counters", 64'({err_cnt, len_err_cnt, pass_cnt}), 64'd0);
    check("t7_timeout", 64'(timeout), 64'd0);
    @(negedge ui_clk);
    ui_rstn = 1'b1;

    // 8: clean run after the reset
    push_incr(0);
    pulse_start(1'b0, 1'b0);
    wait_done("t8_done");
    check_status("t8", 0, 0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
